// File: rtl/vreg_file_v2.sv
// Vector register file: two read / two write ports with per-lane masks, write-first
// forwarding, A-over-B collision merge and a clear sequencer that zeroes the array.

module vreg_lane #(
  parameter int ADDR_W = 4,
  parameter int ELEM_W = 8
) (
  input  logic              i_clk,
  input  logic              i_clr_we,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_wa_a,
  input  logic [ELEM_W-1:0] i_wd_a,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_wa_b,
  input  logic [ELEM_W-1:0] i_wd_b,
  input  logic [ADDR_W-1:0] i_ra_a,
  input  logic [ADDR_W-1:0] i_ra_b,
  output logic [ELEM_W-1:0] o_rd_a,
  output logic [ELEM_W-1:0] o_rd_b
);
  localparam int DEPTH = 2**ADDR_W;

  logic [ELEM_W-1:0] r_mem [DEPTH];

  // Port A is written last so it wins a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_clr_we) begin
      r_mem[i_clr_addr] <= '0;
    end else begin
      if (i_we_b) r_mem[i_wa_b] <= i_wd_b;
      if (i_we_a) r_mem[i_wa_a] <= i_wd_a;
    end
  end

  always_comb begin
    o_rd_a = r_mem[i_ra_a];
    if (i_we_b && (i_wa_b == i_ra_a)) o_rd_a = i_wd_b;
    if (i_we_a && (i_wa_a == i_ra_a)) o_rd_a = i_wd_a;
  end

  always_comb begin
    o_rd_b = r_mem[i_ra_b];
    if (i_we_b && (i_wa_b == i_ra_b)) o_rd_b = i_wd_b;
    if (i_we_a && (i_wa_a == i_ra_b)) o_rd_b = i_wd_a;
  end
endmodule

module vreg_file_v2 #(
  parameter int ADDR_W = 4,
  parameter int ELEM_W = 8,
  parameter int LANES  = 16,
  parameter int VW     = LANES*ELEM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [VW-1:0]     rd_data_a,
  output logic              rd_valid_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [VW-1:0]     rd_data_b,
  output logic              rd_valid_b,
  input  logic              wr_en_a,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [VW-1:0]     wr_data_a,
  input  logic [LANES-1:0]  wr_mask_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [VW-1:0]     wr_data_b,
  input  logic [LANES-1:0]  wr_mask_b,
  input  logic              clr_req,
  output logic              busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                         r_state, w_state_nxt;
  logic [ADDR_W-1:0]              r_idx, w_idx_nxt;
  logic                           w_wr_a, w_wr_b, w_rd_a, w_rd_b;
  logic [LANES-1:0][ELEM_W-1:0]   w_fwd_a, w_fwd_b;
  logic [VW-1:0]                  r_rd_data_a, r_rd_data_b;
  logic                           r_rd_valid_a, r_rd_valid_b;

  assign busy   = (r_state == S_CLEAR);
  assign w_wr_a = wr_en_a & ~busy;
  assign w_wr_b = wr_en_b & ~busy;
  assign w_rd_a = rd_en_a & ~busy;
  assign w_rd_b = rd_en_b & ~busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == LAST_IDX) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vreg_lane #(.ADDR_W(ADDR_W), .ELEM_W(ELEM_W)) u_lane (
      .i_clk      (clk),
      .i_clr_we   (busy),
      .i_clr_addr (r_idx),
      .i_we_a     (w_wr_a & wr_mask_a[g]),
      .i_wa_a     (wr_addr_a),
      .i_wd_a     (wr_data_a[g*ELEM_W +: ELEM_W]),
      .i_we_b     (w_wr_b & wr_mask_b[g]),
      .i_wa_b     (wr_addr_b),
      .i_wd_b     (wr_data_b[g*ELEM_W +: ELEM_W]),
      .i_ra_a     (rd_addr_a),
      .i_ra_b     (rd_addr_b),
      .o_rd_a     (w_fwd_a[g]),
      .o_rd_b     (w_fwd_b[g])
    );
  end

  // Read data holds whenever no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data_a  <= '0;
      r_rd_data_b  <= '0;
      r_rd_valid_a <= 1'b0;
      r_rd_valid_b <= 1'b0;
    end else begin
      r_rd_valid_a <= w_rd_a;
      r_rd_valid_b <= w_rd_b;
      if (w_rd_a) r_rd_data_a <= w_fwd_a;
      if (w_rd_b) r_rd_data_b <= w_fwd_b;
    end
  end

  assign rd_data_a  = r_rd_data_a;
  assign rd_data_b  = r_rd_data_b;
  assign rd_valid_a = r_rd_valid_a;
  assign rd_valid_b = r_rd_valid_b;
endmodule
